uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Single-clock scheduler that drains two byte FIFOs into one UART transmitter. Sits between the read side of two FIFOs (source 0, source 1) and the UART TX engine. It arbitrates between the sources round-robin with a configurable burst allowance, sequences each FIFO read, and runs the start/busy handshake with the transmitter. One byte is in flight at a time.

## Interface
- DW, 8, data width of FIFO entries and tx_data
- BURST, 1, max consecutive grants to one source while the other is also requesting (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  1 = scheduler may start new bytes
- fifo0_empty  in  1  source 0 FIFO empty flag
- fifo0_rdata  in  DW  source 0 read data, registered in the FIFO, valid the cycle after fifo0_rd
- fifo0_rd  out  1  source 0 read strobe, one cycle per byte
- fifo1_empty  in  1  source 1 FIFO empty flag
- fifo1_rdata  in  DW  source 1 read data, same timing as source 0
- fifo1_rd  out  1  source 1 read strobe
- tx_busy  in  1  UART TX busy; rises the cycle after tx_start, falls when the stop bit is done
- tx_start  out  1  one-cycle start pulse to the UART TX
- tx_data  out  DW  byte to transmit; held stable from the tx_start cycle until the return to IDLE
- cur_src  out  1  source of the byte currently or last scheduled
- active  out  1  1 whenever the state is not IDLE

## Operation
- State machine: IDLE → READ → LATCH → SEND → WAIT_BUSY → WAIT_DONE → IDLE.
- IDLE:
  - req0 = !fifo0_empty, req1 = !fifo1_empty.
  - When enable=1 and (req0|req1), select a source, load sel, and go to READ.
- Arbitration: uses registers last_src and burst_cnt (range 1..BURST).
  - Only one source requesting: that source is granted.
  - Both requesting: if burst_cnt < BURST, grant last_src; otherwise grant !last_src.
  - On grant to the same source as last_src: burst_cnt ← min(burst_cnt+1, BURST).
  - On grant to the other source: burst_cnt ← 1 and last_src ← the granted source.
- READ: fifoN_rd = 1 for sel only, for exactly one cycle. The other read strobe stays 0.
- LATCH: tx_data ← fifoN_rdata(sel).
- SEND: tx_start = 1 for exactly one cycle.
- WAIT_BUSY: remain until tx_busy = 1, then go to WAIT_DONE.
- WAIT_DONE: remain until tx_busy = 0, then go to IDLE.
- cur_src = sel. It updates on entry to READ.
- enable is sampled only in IDLE. Dropping enable mid-byte does not abort the byte; the byte completes and the block then stays in IDLE.
- Both FIFOs are read only by this block. An empty flag seen at 0 in IDLE therefore stays valid through READ.
- fifo0_rd, fifo1_rd and tx_start are never asserted together, and none of them is asserted outside the states listed above.

## Timing
- Reset values, set on the clk edge where rst=1:
  - state = IDLE
  - fifo0_rd = fifo1_rd = tx_start = 0
  - tx_data = 0
  - cur_src = 0
  - active = 0
  - last_src = 1, burst_cnt = BURST, so the first contested grant goes to source 0.
- Reset mid-operation: state returns to IDLE unconditionally. Any in-progress strobe is low from the next cycle. A byte already read from a FIFO is discarded.
- Latency, with request seen in IDLE in cycle N:
  - rd high in cycle N+1
  - tx_data valid from cycle N+3
  - tx_start high in cycle N+3
- With busy high in N+4 and low in cycle M, the state is IDLE in M+1. The next rd can be high in M+2.
- Back-to-back throughput: one byte per (UART frame + 5 cycles).
- rd, tx_start and active are decoded from registered state/sel and contain no combinational path from inputs. tx_data is a register.
- tx_busy already high in SEND: WAIT_BUSY still waits one cycle, then sees busy=1 and proceeds. No hang.

## Test plan
- **Single byte.** Reset; fifo0_empty=0 with rdata 0xA5, fifo1 empty, enable=1.
  - fifo0_rd pulses once.
  - tx_start pulses 2 cycles later with tx_data=0xA5, and cur_src=0.
  - active falls 1 cycle after tx_busy falls.
- **Contention, BURST=1.** Both FIFOs hold 3 bytes (0x10.., 0x20..).
  - tx_data order: 0x10,0x20,0x11,0x21,0x12,0x22.
  - Exactly 3 rd pulses per source.
- **Contention, BURST=2.** Same stimulus.
  - Order: 0x10,0x11,0x20,0x21,0x12,0x22.
- **Enable dropped during WAIT_DONE,** with bytes remaining.
  - The current byte completes.
  - No further rd or tx_start while enable=0.
  - Resume on enable=1, with the first rd 1 cycle after IDLE samples enable.
- **Reset in LATCH.**
  - tx_start never pulses.
  - Outputs are at reset values the next cycle.
  - After rst release, the next contested grant goes to source 0.
- **Slow busy.** tx_busy rises 5 cycles late and tx_busy is held for 100 cycles.
  - No second tx_start.
  - tx_data stays stable throughout.
  - IDLE is reached 1 cycle after busy falls.

Source files
------------

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin burst scheduler draining two byte FIFOs into one UART TX
module uart_tx_sched #(
    parameter int DW    = 8,
    parameter int BURST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          fifo0_empty,
    input  logic [DW-1:0] fifo0_rdata,
    output logic          fifo0_rd,
    input  logic          fifo1_empty,
    input  logic [DW-1:0] fifo1_rdata,
    output logic          fifo1_rd,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [DW-1:0] tx_data,
    output logic          cur_src,
    output logic          active
);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] BMAX = CW'(BURST);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t        state, state_nxt;
    logic          sel;
    logic          last_src;
    logic [CW-1:0] burst_cnt;
    logic          req0, req1;
    logic          grant;
    logic          start_byte;

    always_comb begin
        req0       = !fifo0_empty;
        req1       = !fifo1_empty;
        grant      = req1;
        if (req0 && req1)
            grant = (burst_cnt < BMAX) ? last_src : !last_src;
        start_byte = (state == IDLE) && enable && (req0 || req1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start_byte) state_nxt = READ;
            READ:      state_nxt = LATCH;
            LATCH:     state_nxt = SEND;
            SEND:      state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy) state_nxt = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // last_src/burst_cnt start as if source 1 just used its full allowance,
    // so the first contested grant after reset goes to source 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 1'b0;
            last_src  <= 1'b1;
            burst_cnt <= BMAX;
            tx_data   <= '0;
        end else begin
            state <= state_nxt;
            if (start_byte) begin
                sel <= grant;
                if (grant == last_src) begin
                    burst_cnt <= (burst_cnt < BMAX) ? burst_cnt + 1'b1 : BMAX;
                end else begin
                    burst_cnt <= CW'(1);
                    last_src  <= grant;
                end
            end
            if (state == LATCH)
                tx_data <= sel ? fifo1_rdata : fifo0_rdata;
        end
    end

    assign fifo0_rd = (state == READ) && !sel;
    assign fifo1_rd = (state == READ) && sel;
    assign tx_start = (state == SEND);
    assign active   = (state != IDLE);
    assign cur_src  = sel;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched (BURST=1 and BURST=2)
module tb_uart_tx_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       f_empty [2][2];
    logic [7:0] f_rdata [2][2];
    logic       f_rd    [2][2];
    logic       busy    [2];
    logic       start   [2];
    logic [7:0] txd     [2];
    logic       cur_src [2];
    logic       active  [2];

    logic [7:0] mem [2][2][32];
    int         wp [2][2];
    int         rp [2][2];
    int         lat, len;
    int         rise_cd [2];
    int         hold_cd [2];

    int         n_rd  [2][2];
    int         n_log [2];
    logic [7:0] log_d [2][64];
    logic       log_s [2][64];
    int         viol  [2];

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_b1 [6] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    logic [7:0] exp_b2 [6] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h22};

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        assign f_empty[k][0] = (rp[k][0] == wp[k][0]);
        assign f_empty[k][1] = (rp[k][1] == wp[k][1]);
        uart_tx_sched #(.DW(8), .BURST(k + 1)) dut (
            .clk         (clk),
            .rst         (rst),
            .enable      (enable),
            .fifo0_empty (f_empty[k][0]),
            .fifo0_rdata (f_rdata[k][0]),
            .fifo0_rd    (f_rd[k][0]),
            .fifo1_empty (f_empty[k][1]),
            .fifo1_rdata (f_rdata[k][1]),
            .fifo1_rd    (f_rd[k][1]),
            .tx_busy     (busy[k]),
            .tx_start    (start[k]),
            .tx_data     (txd[k]),
            .cur_src     (cur_src[k]),
            .active      (active[k])
        );
    end

    // FIFO read ports, UART busy model and transaction monitor
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) begin
                if (f_rd[k][s]) begin
                    f_rdata[k][s] <= mem[k][s][rp[k][s] % 32];
                    rp[k][s]      <= rp[k][s] + 1;
                    n_rd[k][s]    <= n_rd[k][s] + 1;
                end
            end
            if (rst) begin
                busy[k]    <= 1'b0;
                rise_cd[k] <= 0;
                hold_cd[k] <= 0;
            end else if (start[k]) begin
                if (lat == 1) begin
                    busy[k]    <= 1'b1;
                    hold_cd[k] <= len;
                end else begin
                    rise_cd[k] <= lat - 1;
                end
            end else if (rise_cd[k] > 0) begin
                rise_cd[k] <= rise_cd[k] - 1;
                if (rise_cd[k] == 1) begin
                    busy[k]    <= 1'b1;
                    hold_cd[k] <= len;
                end
            end else if (busy[k]) begin
                if (hold_cd[k] == 1) busy[k] <= 1'b0;
                hold_cd[k] <= hold_cd[k] - 1;
            end
            if ((f_rd[k][0] && f_rd[k][1]) || ((f_rd[k][0] || f_rd[k][1]) && start[k]))
                viol[k] <= viol[k] + 1;
            if (start[k]) begin
                log_d[k][n_log[k] % 64] <= txd[k];
                log_s[k][n_log[k] % 64] <= cur_src[k];
                n_log[k]                <= n_log[k] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input int s, input logic [7:0] d);
        mem[k][s][wp[k][s] % 32] = d;
        wp[k][s]++;
    endtask

    initial begin
        int sb, rb, b0, b1, r0, r1, r2, r3;
        logic stable, extra, seen;
        rst = 1'b1; enable = 1'b0; lat = 1; len = 3;
        repeat (3) @(negedge clk);
        chk("reset_rd0", f_rd[0][0], 0);
        chk("reset_rd1", f_rd[0][1], 0);
        chk("reset_start", start[0], 0);
        chk("reset_txd", txd[0], 0);
        chk("reset_cur_src", cur_src[0], 0);
        chk("reset_active", active[0], 0);

        // single byte from source 0
        rst = 1'b0; enable = 1'b1; push(0, 0, 8'hA5);
        @(negedge clk);
        chk("single_rd0", f_rd[0][0], 1);
        chk("single_rd1", f_rd[0][1], 0);
        chk("single_cur_src", cur_src[0], 0);
        chk("single_active", active[0], 1);
        @(negedge clk);
        chk("single_rd0_once", f_rd[0][0], 0);
        chk("single_no_early_start", start[0], 0);
        @(negedge clk);
        chk("single_start", start[0], 1);
        chk("single_txd", txd[0], 8'hA5);
        repeat (4) @(negedge clk);
        chk("single_active_busy_low", active[0], 1);
        @(negedge clk);
        chk("single_idle_after_busy", active[0], 0);
        chk("single_rd_count", n_rd[0][0], 1);

        // contention, both instances, from fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b0 = n_log[0]; b1 = n_log[1];
        r0 = n_rd[0][0]; r1 = n_rd[0][1]; r2 = n_rd[1][0]; r3 = n_rd[1][1];
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 2; k++) begin
                push(k, 0, 8'h10 + 8'(i));
                push(k, 1, 8'h20 + 8'(i));
            end
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (n_log[0] >= b0 + 6 && n_log[1] >= b1 + 6 && !active[0] && !active[1]) break;
        end
        chk("cont_b1_count", n_log[0] - b0, 6);
        chk("cont_b2_count", n_log[1] - b1, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("cont_b1_byte%0d", i), log_d[0][b0 + i], exp_b1[i]);
            chk($sformatf("cont_b2_byte%0d", i), log_d[1][b1 + i], exp_b2[i]);
        end
        chk("cont_b1_rd0", n_rd[0][0] - r0, 3);
        chk("cont_b1_rd1", n_rd[0][1] - r1, 3);
        chk("cont_b2_rd0", n_rd[1][0] - r2, 3);
        chk("cont_b2_rd1", n_rd[1][1] - r3, 3);

        // enable dropped in WAIT_DONE with a byte still queued
        b0 = n_log[0];
        push(0, 0, 8'h30); push(0, 0, 8'h31);
        repeat (5) @(negedge clk);
        chk("en_mid_active", active[0], 1);
        enable = 1'b0;
        sb = n_log[0]; rb = n_rd[0][0];
        repeat (20) @(negedge clk);
        chk("en_off_idle", active[0], 0);
        chk("en_off_no_start", n_log[0], sb);
        chk("en_off_no_rd", n_rd[0][0], rb);
        chk("en_off_fifo_kept", f_empty[0][0], 0);
        enable = 1'b1;
        @(negedge clk);
        chk("en_resume_rd", f_rd[0][0], 1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!active[0] && n_log[0] > sb) break;
        end
        chk("en_first_byte", log_d[0][b0], 8'h30);
        chk("en_second_byte", log_d[0][b0 + 1], 8'h31);

        // reset while in LATCH
        push(0, 0, 8'h40); push(0, 1, 8'h50);
        @(negedge clk);
        chk("rst_latch_rd1", f_rd[0][1], 1);
        chk("rst_latch_cur_src", cur_src[0], 1);
        @(negedge clk);
        rst = 1'b1;
        sb = n_log[0];
        @(negedge clk);
        chk("rst_latch_rd0", f_rd[0][0], 0);
        chk("rst_latch_rd1_low", f_rd[0][1], 0);
        chk("rst_latch_start", start[0], 0);
        chk("rst_latch_txd", txd[0], 0);
        chk("rst_latch_cur_src0", cur_src[0], 0);
        chk("rst_latch_active", active[0], 0);
        rst = 1'b0;
        push(0, 0, 8'h41); push(0, 1, 8'h51);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (f_empty[0][0] && f_empty[0][1] && !active[0]) break;
        end
        enable = 1'b0;
        chk("rst_latch_n_bytes", n_log[0] - sb, 3);
        chk("rst_after_byte0", log_d[0][sb], 8'h40);
        chk("rst_after_src0", log_s[0][sb], 0);
        chk("rst_after_byte1", log_d[0][sb + 1], 8'h51);
        chk("rst_after_byte2", log_d[0][sb + 2], 8'h41);

        // slow busy: rises 5 cycles late, held 100 cycles
        lat = 6; len = 100;
        sb = n_log[0];
        push(0, 0, 8'h77); enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("slow_start", start[0], 1);
        chk("slow_txd", txd[0], 8'h77);
        stable = 1'b1; extra = 1'b0; seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (start[0]) extra = 1'b1;
            if (txd[0] !== 8'h77) stable = 1'b0;
            if (busy[0]) seen = 1'b1;
            else if (seen) break;
        end
        chk("slow_busy_seen", seen, 1);
        chk("slow_no_restart", extra, 0);
        chk("slow_txd_stable", stable, 1);
        chk("slow_active_at_fall", active[0], 1);
        @(negedge clk);
        chk("slow_idle_after_fall", active[0], 0);
        chk("slow_one_start", n_log[0] - sb, 1);

        chk("strobe_overlap_b1", viol[0], 0);
        chk("strobe_overlap_b2", viol[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
